// File: rtl/edge_hessian_check_if.sv
// Stream interface for edge_hessian_check: derivative beats in, trace/determinant/keep beats out.
interface edge_hessian_check_if #(
  parameter int DW = 9
);
  logic                  ivalid;
  logic                  iready;
  logic signed [DW-1:0]  idxx;
  logic signed [DW-1:0]  idyy;
  logic signed [DW-1:0]  idxy;
  logic                  ovalid;
  logic                  oready;
  logic signed [DW:0]    otr;
  logic signed [2*DW:0]  odet;
  logic                  okeep;

  modport master (
    output ivalid, idxx, idyy, idxy, oready,
    input  iready, ovalid, otr, odet, okeep
  );

  modport slave (
    input  ivalid, idxx, idyy, idxy, oready,
    output iready, ovalid, otr, odet, okeep
  );
endinterface

// File: rtl/edge_hessian_check.sv
// 3-stage Hessian trace/determinant with Lowe edge rejection and global-stall flow control.
// Optional keep/reject statistics counters are enabled by defining EDGE_HESSIAN_STAT_EN.
module edge_hessian_check #(
  parameter int DW = 9,
  parameter int R  = 10   // edge ratio threshold, legal 1..31
) (
  input  logic                 iclk,
  input  logic                 irst,
  edge_hessian_check_if.slave  bus
`ifdef EDGE_HESSIAN_STAT_EN
  ,
  input  logic                 iclr_stat,
  output logic [15:0]          ocnt_keep,
  output logic [15:0]          ocnt_rej
`endif
);

  localparam int TW  = DW + 1;      // trace width
  localparam int PW  = 2 * DW;      // product width
  localparam int DTW = 2 * DW + 1;  // determinant width
  localparam int T2W = 2 * DW + 2;  // squared trace width
  localparam int CW  = 2 * DW + 14; // edge-test comparison width

  localparam logic [CW-1:0] R_C = CW'(R);
  localparam logic [CW-1:0] K_C = CW'((R + 1) * (R + 1));

  logic adv;
  logic accept;

  assign adv        = !bus.ovalid || bus.oready;
  assign bus.iready = adv;
  assign accept     = bus.ivalid && adv;

  // Stage 1 datapath
  logic signed [TW-1:0] tr_d;
  logic signed [PW-1:0] xx_w, yy_w, xy_w;
  logic signed [PW-1:0] p1_d, p2_d;

  assign tr_d = {bus.idxx[DW-1], bus.idxx} + {bus.idyy[DW-1], bus.idyy};
  assign xx_w = {{DW{bus.idxx[DW-1]}}, bus.idxx};
  assign yy_w = {{DW{bus.idyy[DW-1]}}, bus.idyy};
  assign xy_w = {{DW{bus.idxy[DW-1]}}, bus.idxy};
  assign p1_d = xx_w * yy_w;
  assign p2_d = xy_w * xy_w;

  logic                 s1_v;
  logic signed [TW-1:0] s1_tr;
  logic signed [PW-1:0] s1_p1, s1_p2;

  // NOTE: all clocked state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      s1_v  <= 1'b0;
      s1_tr <= '0;
      s1_p1 <= '0;
      s1_p2 <= '0;
    end else if (adv) begin
      s1_v  <= accept;
      s1_tr <= tr_d;
      s1_p1 <= p1_d;
      s1_p2 <= p2_d;
    end
  end

  // Stage 2 datapath
  logic signed [DTW-1:0] det_d;
  logic signed [T2W-1:0] tr_w2;
  logic        [T2W-1:0] tr2_d;

  assign det_d = {s1_p1[PW-1], s1_p1} - {s1_p2[PW-1], s1_p2};
  assign tr_w2 = {{(T2W-TW){s1_tr[TW-1]}}, s1_tr};
  assign tr2_d = tr_w2 * tr_w2;

  logic                  s2_v;
  logic signed [TW-1:0]  s2_tr;
  logic signed [DTW-1:0] s2_det;
  logic        [T2W-1:0] s2_tr2;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      s2_v   <= 1'b0;
      s2_tr  <= '0;
      s2_det <= '0;
      s2_tr2 <= '0;
    end else if (adv) begin
      s2_v   <= s1_v;
      s2_tr  <= s1_tr;
      s2_det <= det_d;
      s2_tr2 <= tr2_d;
    end
  end

  // Stage 3: edge test, widened so neither side can truncate
  logic [CW-1:0] lhs, rhs;
  logic          keep_d;

  assign lhs    = {{(CW-T2W){1'b0}}, s2_tr2} * R_C;
  assign rhs    = {{(CW-DTW){s2_det[DTW-1]}}, s2_det} * K_C;
  assign keep_d = !s2_det[DTW-1] && (s2_det != '0) && (lhs < rhs);

  // Output data only reloads on a real beat so it keeps its last value across bubbles.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      bus.ovalid <= 1'b0;
      bus.otr    <= '0;
      bus.odet   <= '0;
      bus.okeep  <= 1'b0;
    end else if (adv) begin
      bus.ovalid <= s2_v;
      if (s2_v) begin
        bus.otr   <= s2_tr;
        bus.odet  <= s2_det;
        bus.okeep <= keep_d;
      end
    end
  end

`ifdef EDGE_HESSIAN_STAT_EN
  logic consume;
  assign consume = bus.ovalid && bus.oready;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      ocnt_keep <= '0;
      ocnt_rej  <= '0;
    end else if (iclr_stat) begin
      ocnt_keep <= '0;
      ocnt_rej  <= '0;
    end else if (consume) begin
      if (bus.okeep) begin
        if (ocnt_keep != 16'hFFFF) ocnt_keep <= ocnt_keep + 16'd1;
      end else begin
        if (ocnt_rej != 16'hFFFF) ocnt_rej <= ocnt_rej + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_edge_hessian_check.sv
// Scoreboard bench for edge_hessian_check: directed test-plan vectors, backpressure, random traffic, mid-stream reset.
module tb_edge_hessian_check;

  localparam int DW = 9;
  localparam int R  = 10;

  typedef struct {
    longint tr;
    longint det;
    bit     keep;
    int     cyc;
  } exp_t;

  logic iclk;
  logic irst;
  edge_hessian_check_if #(.DW(DW)) bus ();

`ifdef EDGE_HESSIAN_STAT_EN
  logic        iclr_stat;
  logic [15:0] ocnt_keep;
  logic [15:0] ocnt_rej;
`endif

  edge_hessian_check #(.DW(DW), .R(R)) dut (
    .iclk      (iclk),
    .irst      (irst),
    .bus       (bus.slave)
`ifdef EDGE_HESSIAN_STAT_EN
    ,
    .iclr_stat (iclr_stat),
    .ocnt_keep (ocnt_keep),
    .ocnt_rej  (ocnt_rej)
`endif
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   chk_lat  = 1'b0;
  int   mk       = 0;
  int   mr       = 0;
  exp_t sb[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int c);
    exp_t   m;
    longint lhs, rhs;
    m.tr   = longint'(a) + longint'(b);
    m.det  = longint'(a) * b - longint'(c) * c;
    lhs    = m.tr * m.tr * R;
    rhs    = m.det * (R + 1) * (R + 1);
    m.keep = (m.det > 0) && (lhs < rhs);
    m.cyc  = 0;
    return m;
  endfunction

  // Monitor: push expectations on accept, compare on consume, check hold on stall.
  initial begin
    exp_t e;
    forever begin
      @(negedge iclk);
      cyc++;
      if (irst) begin
        sb.delete();
        mk = 0;
        mr = 0;
      end else begin
        if (bus.ovalid) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else if (bus.oready) begin
            e = sb.pop_front();
            check("otr", bus.otr, e.tr);
            check("odet", bus.odet, e.det);
            check("okeep", bus.okeep, e.keep);
            if (chk_lat) check("latency", cyc - e.cyc, 3);
            if (e.keep) mk++; else mr++;
          end else begin
            e = sb[0];
            check("hold_otr", bus.otr, e.tr);
            check("hold_odet", bus.odet, e.det);
            check("hold_okeep", bus.okeep, e.keep);
            check("stall_iready", bus.iready, 0);
          end
        end
        if (bus.ivalid && bus.iready) begin
          e     = model(bus.idxx, bus.idyy, bus.idxy);
          e.cyc = cyc;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic send(input int a, input int b, input int c);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    bus.ivalid = 1'b1;
    bus.idxx   = a[DW-1:0];
    bus.idyy   = b[DW-1:0];
    bus.idxy   = c[DW-1:0];
    while (!acc && guard < 100) begin
      @(negedge iclk);
      acc = bus.iready;
      @(posedge iclk);
      #1;
      guard++;
    end
    if (!acc) check("send_timeout", 0, 1);
    bus.ivalid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || bus.ovalid) && g < 100) begin
      @(posedge iclk);
      #1;
      g++;
    end
    if (g >= 100) check("drain_timeout", 0, 1);
  endtask

  task automatic check_stats(input string tag);
`ifdef EDGE_HESSIAN_STAT_EN
    check({tag, "_cnt_keep"}, ocnt_keep, mk);
    check({tag, "_cnt_rej"}, ocnt_rej, mr);
`else
    if (tag.len() < 0) check(tag, 0, 0);
`endif
  endtask

  int dir_tab [6][3] = '{
    '{  10,   10,    0},
    '{ 100,    1,    0},
    '{  10,    1,    0},
    '{   5,   -5,    3},
    '{-256, -256,    0},
    '{-256, -256, -256}
  };

  initial begin
    bit done;
    bus.ivalid = 1'b0;
    bus.idxx   = '0;
    bus.idyy   = '0;
    bus.idxy   = '0;
    bus.oready = 1'b1;
`ifdef EDGE_HESSIAN_STAT_EN
    iclr_stat = 1'b0;
`endif
    irst = 1'b1;
    repeat (3) @(posedge iclk);
    #1;
    check("rst_ovalid", bus.ovalid, 0);
    check("rst_otr", bus.otr, 0);
    check("rst_odet", bus.odet, 0);
    check("rst_okeep", bus.okeep, 0);
    irst = 1'b0;
    @(posedge iclk);
    #1;
    check("idle_iready", bus.iready, 1);

    // Directed test-plan vectors, back to back with oready high
    chk_lat = 1'b1;
    for (int i = 0; i < 6; i++) send(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2]);
    drain();
    chk_lat = 1'b0;
    check_stats("dir");

    // Five beats with oready dropped for 4 cycles once output appears
    fork
      begin
        for (int i = 0; i < 5; i++) send(i * 7 - 10, 20 - i * 3, i);
      end
      begin
        int g;
        g = 0;
        while (!bus.ovalid && g < 50) begin
          @(posedge iclk);
          #1;
          g++;
        end
        check("bp_first_out", bus.ovalid, 1);
        bus.oready = 1'b0;
        repeat (4) begin
          @(posedge iclk);
          #1;
          check("bp_iready_low", bus.iready, 0);
        end
        bus.oready = 1'b1;
      end
    join
    drain();
    check("bp_sb_empty", sb.size(), 0);
    check_stats("bp");

    // Random traffic with random backpressure and input gaps
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge iclk);
            #1;
          end
          send(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
               int'($urandom_range(0, 511)) - 256);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.oready = ($urandom_range(0, 3) != 0);
          @(posedge iclk);
          #1;
        end
        bus.oready = 1'b1;
      end
    join
    drain();
    check("rnd_sb_empty", sb.size(), 0);
    check_stats("rnd");

`ifdef EDGE_HESSIAN_STAT_EN
    iclr_stat = 1'b1;
    @(posedge iclk);
    #1;
    iclr_stat = 1'b0;
    mk = 0;
    mr = 0;
    check_stats("clr");
`endif

    // Reset asserted with beats in flight
    for (int i = 0; i < 4; i++) send(30 + i, 40, 2);
    check("pre_rst_ovalid", bus.ovalid, 1);
    irst = 1'b1;
    #1;
    check("mid_rst_ovalid", bus.ovalid, 0);
    check("mid_rst_otr", bus.otr, 0);
    repeat (2) @(posedge iclk);
    #1;
    irst = 1'b0;
    repeat (8) @(posedge iclk);
    #1;
    check("post_rst_quiet", bus.ovalid, 0);
    check_stats("rst");
    send(10, 10, 0);
    drain();
    check_stats("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
